// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath (conv_fix, line buffer, collector).
package conv_pkg;

  localparam int unsigned CONV_DW = 32;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } coll_state_e;

endpackage

// File: rtl/conv_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
module conv_sdp_ram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_result_collect.sv
// Buffers one frame of conv_fix results (optional ReLU), then drains it in order
// over a valid/ready stream with a prefetch stage for full throughput.
module conv_result_collect
  import conv_pkg::*;
#(
  parameter int unsigned  DW    = CONV_DW,
  parameter int unsigned  DEPTH = 64,
  parameter bit           RELU  = 1'b0,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [DW-1:0] result,
  input  logic          out_valid,
  input  logic          end_conv,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [AW:0]   count,
  output logic          frame_done,
  output logic          overflow,
  output logic          busy
);

  localparam int unsigned CW   = AW + 1;
  localparam logic [AW:0] FULL = CW'(DEPTH);

  coll_state_e   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   fetch_left_q, fetch_left_d;
  logic          pf_vld_q, pf_vld_d;
  logic          pf_last_q, pf_last_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;

  logic          ram_we_c, ram_re_c;
  logic          hs_c, load_c, issue_c;
  logic [DW-1:0] wdata_c;
  logic [DW-1:0] ram_rdata;

  assign wdata_c = (RELU && result[DW-1]) ? '0 : result;

  conv_sdp_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_c),
    .re_i    (ram_re_c),
    .raddr_i (fetch_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state: capture in COLLECT; in DRAIN the RAM output acts as a prefetch slot
  // feeding the output register so one entry can leave per cycle.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fetch_ptr_d  = fetch_ptr_q;
    count_d      = count_q;
    fetch_left_d = fetch_left_q;
    pf_vld_d     = pf_vld_q;
    pf_last_d    = pf_last_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    ram_we_c     = 1'b0;
    ram_re_c     = 1'b0;
    hs_c         = m_valid_q && m_ready;
    load_c       = 1'b0;
    issue_c      = 1'b0;

    case (state_q)
      COLLECT: begin
        if (out_valid) begin
          if (count_q == FULL) begin
            overflow_d = 1'b1;
          end else begin
            ram_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
          end
        end
        // A result arriving with end_conv already sits in count_d.
        if (end_conv && (count_d != '0)) begin
          state_d      = DRAIN;
          fetch_ptr_d  = '0;
          fetch_left_d = count_d;
        end
      end

      DRAIN: begin
        if (out_valid) begin
          overflow_d = 1'b1;
        end
        load_c  = pf_vld_q && (!m_valid_q || m_ready);
        issue_c = (fetch_left_q != '0) && (!pf_vld_q || load_c);
        if (issue_c) begin
          ram_re_c     = 1'b1;
          fetch_ptr_d  = fetch_ptr_q + AW'(1);
          fetch_left_d = fetch_left_q - CW'(1);
          pf_last_d    = (fetch_left_q == CW'(1));
        end
        pf_vld_d = issue_c || (pf_vld_q && !load_c);
        if (hs_c) begin
          count_d   = count_q - CW'(1);
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
        if (load_c) begin
          m_data_d  = ram_rdata;
          m_valid_d = 1'b1;
          m_last_d  = pf_last_q;
        end
        if (hs_c && m_last_q) begin
          state_d      = COLLECT;
          frame_done_d = 1'b1;
          wr_ptr_d     = '0;
          fetch_ptr_d  = '0;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase

    busy_d = (state_d == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= COLLECT;
      wr_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      count_q      <= '0;
      fetch_left_q <= '0;
      pf_vld_q     <= 1'b0;
      pf_last_q    <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      count_q      <= count_d;
      fetch_left_q <= fetch_left_d;
      pf_vld_q     <= pf_vld_d;
      pf_last_q    <= pf_last_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign count      = count_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_conv_result_collect.sv
// Bench for conv_result_collect: two instances (RELU=0 / RELU=1) share stimulus and are
// checked every cycle against a frame-level queue model, plus literal drained-value checks.
module tb_conv_result_collect;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] result;
  logic          out_valid;
  logic          end_conv;
  logic          m_ready;
  logic [DW-1:0] m_data     [2];
  logic          m_valid    [2];
  logic          m_last     [2];
  logic [AW:0]   count      [2];
  logic          frame_done [2];
  logic          overflow   [2];
  logic          busy       [2];

  always #5 clk = ~clk;

  conv_result_collect #(.DEPTH(DEPTH), .RELU(1'b0)) dut0 (
    .clock(clk), .rst(rst), .result(result), .out_valid(out_valid), .end_conv(end_conv),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready), .m_last(m_last[0]),
    .count(count[0]), .frame_done(frame_done[0]), .overflow(overflow[0]), .busy(busy[0])
  );

  conv_result_collect #(.DEPTH(DEPTH), .RELU(1'b1)) dut1 (
    .clock(clk), .rst(rst), .result(result), .out_valid(out_valid), .end_conv(end_conv),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready), .m_last(m_last[1]),
    .count(count[1]), .frame_done(frame_done[1]), .overflow(overflow[1]), .busy(busy[1])
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;
  bit chk_en   = 1'b0;

  // Frame model: raw captured results in order, drain phase age, sticky overflow.
  logic [DW-1:0] mq [$];
  bit            mdrain = 1'b0;
  int            mage   = 0;
  bit            movf   = 1'b0;
  bit            mfd    = 1'b0;

  logic [DW-1:0] dlog0 [$];
  logic [DW-1:0] dlog1 [$];
  logic [DW-1:0] exp_q [$];
  int            fd_cnt0 = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [dut%0d] cycle %0d: got %0h expected %0h", name, k, cyc_n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit v;
    cyc_n++;
    v   = mdrain && (mage >= 2);
    mfd = 1'b0;
    if (rst) begin
      mq.delete();
      mdrain = 1'b0;
      mage   = 0;
      movf   = 1'b0;
    end else if (!mdrain) begin
      if (out_valid) begin
        if (mq.size() < DEPTH) mq.push_back(result);
        else movf = 1'b1;
      end
      if (end_conv && (mq.size() != 0)) begin
        mdrain = 1'b1;
        mage   = 0;
      end
    end else begin
      if (out_valid) movf = 1'b1;
      if (mage < 2) mage++;
      if (v && m_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          mdrain = 1'b0;
          mfd    = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit            ev;
    logic [DW-1:0] ed;
    if (chk_en) begin
      ev = mdrain && (mage >= 2);
      for (int k = 0; k < 2; k++) begin
        chk("m_valid", k, 64'(m_valid[k]), 64'(ev));
        if (ev) begin
          ed = mq[0];
          if (k == 1 && ed[DW-1]) ed = '0;
          chk("m_data", k, 64'(m_data[k]), 64'(ed));
          chk("m_last", k, 64'(m_last[k]), 64'(mq.size() == 1));
        end else begin
          chk("m_last", k, 64'(m_last[k]), 64'(0));
        end
        chk("count", k, 64'(count[k]), 64'(mq.size()));
        chk("busy", k, 64'(busy[k]), 64'(mdrain));
        chk("frame_done", k, 64'(frame_done[k]), 64'(mfd));
        chk("overflow", k, 64'(overflow[k]), 64'(movf));
      end
    end
    if (m_valid[0] === 1'b1 && m_ready === 1'b1) dlog0.push_back(m_data[0]);
    if (m_valid[1] === 1'b1 && m_ready === 1'b1) dlog1.push_back(m_data[1]);
    if (frame_done[0] === 1'b1) fd_cnt0++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v, input logic ec);
    result    = v;
    out_valid = 1'b1;
    end_conv  = ec;
    cyc();
    out_valid = 1'b0;
    end_conv  = 1'b0;
  endtask

  task automatic pulse_end();
    end_conv = 1'b1;
    cyc();
    end_conv = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy[0] === 1'b1 && i < 400) begin
      cyc();
      i++;
    end
    chk(name, 0, 64'(busy[0]), 64'(0));
    cyc();
    cyc();
  endtask

  task automatic chk_log(input string name, input int k);
    int n;
    n = (k == 0) ? dlog0.size() : dlog1.size();
    chk({name, "_len"}, k, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk(name, k, 64'((k == 0) ? dlog0[i] : dlog1[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic clr_logs();
    dlog0.delete();
    dlog1.delete();
  endtask

  initial begin
    rst       = 1'b1;
    result    = '0;
    out_valid = 1'b0;
    end_conv  = 1'b0;
    m_ready   = 1'b1;
    cyc();
    cyc();
    chk_en = 1'b1;
    rst    = 1'b0;

    // Reset values
    chk("rst_m_valid", 0, 64'(m_valid[0]), 64'(0));
    chk("rst_m_data", 0, 64'(m_data[0]), 64'(0));
    chk("rst_count", 0, 64'(count[0]), 64'(0));
    chk("rst_busy", 0, 64'(busy[0]), 64'(0));
    chk("rst_overflow", 0, 64'(overflow[0]), 64'(0));

    // 1: basic frame
    clr_logs();
    push(32'h20, 1'b0);
    push(32'h40, 1'b0);
    push(32'h60, 1'b0);
    push(32'h80, 1'b0);
    pulse_end();
    wait_idle("t1_timeout");
    exp_q = {32'h20, 32'h40, 32'h60, 32'h80};
    chk_log("t1_data", 0);
    chk("t1_frame_done_cnt", 0, 64'(fd_cnt0), 64'(1));
    chk("t1_count", 0, 64'(count[0]), 64'(0));

    // 2: backpressure
    clr_logs();
    push(32'h111, 1'b0);
    push(32'h222, 1'b0);
    push(32'h333, 1'b0);
    m_ready = 1'b0;
    pulse_end();
    cyc();
    begin
      logic [5:0] pat;
      pat = 6'b110010;
      for (int i = 0; i < 6; i++) begin
        m_ready = pat[i];
        cyc();
      end
    end
    m_ready = 1'b1;
    wait_idle("t2_timeout");
    exp_q = {32'h111, 32'h222, 32'h333};
    chk_log("t2_data", 0);
    chk("t2_frame_done_cnt", 0, 64'(fd_cnt0), 64'(2));

    // 3: full buffer and overflow
    clr_logs();
    for (int i = 1; i <= DEPTH + 2; i++) push(DW'(i), 1'b0);
    chk("t3_count_full", 0, 64'(count[0]), 64'(64));
    chk("t3_overflow", 0, 64'(overflow[0]), 64'(1));
    pulse_end();
    wait_idle("t3_timeout");
    exp_q.delete();
    for (int i = 1; i <= DEPTH; i++) exp_q.push_back(DW'(i));
    chk_log("t3_data", 0);
    do_reset();

    // 4: result together with end_conv
    clr_logs();
    push(32'h5, 1'b0);
    push(32'hDEAD, 1'b1);
    wait_idle("t4_timeout");
    exp_q = {32'h5, 32'hDEAD};
    chk_log("t4_data", 0);

    // 5: ReLU on capture
    clr_logs();
    push(32'hFFFF_FFF0, 1'b0);
    push(32'h0000_0010, 1'b0);
    pulse_end();
    wait_idle("t5_timeout");
    exp_q = {32'hFFFF_FFF0, 32'h10};
    chk_log("t5_raw", 0);
    exp_q = {32'h0, 32'h10};
    chk_log("t5_relu", 1);

    // 6: reset mid-drain, then empty frame
    clr_logs();
    fd_cnt0 = 0;
    push(32'h7, 1'b0);
    push(32'h8, 1'b0);
    push(32'h9, 1'b0);
    m_ready = 1'b0;
    pulse_end();
    cyc();
    cyc();
    push(32'hBAD, 1'b0);
    cyc();
    chk("t6_stalled_valid", 0, 64'(m_valid[0]), 64'(1));
    chk("t6_drain_overflow", 0, 64'(overflow[0]), 64'(1));
    do_reset();
    chk("t6_rst_valid", 0, 64'(m_valid[0]), 64'(0));
    chk("t6_rst_busy", 0, 64'(busy[0]), 64'(0));
    chk("t6_rst_count", 0, 64'(count[0]), 64'(0));
    chk("t6_rst_overflow", 0, 64'(overflow[0]), 64'(0));
    m_ready = 1'b1;
    pulse_end();
    for (int i = 0; i < 6; i++) cyc();
    chk("t6_empty_busy", 0, 64'(busy[0]), 64'(0));
    chk("t6_empty_frame_done", 0, 64'(fd_cnt0), 64'(0));
    chk("t6_empty_drained", 0, 64'(dlog0.size()), 64'(0));

    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
